// File: rtl/prog_mem_pkg.sv
// rtl/prog_mem_pkg.sv - shared FSM state type and default NOP word for prog_mem
package prog_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  // Wide enough for any sensible instruction width; the top slices it down.
  localparam logic [63:0] NOP_DEFAULT = 64'h0;

endpackage

// File: rtl/prog_mem_array.sv
// rtl/prog_mem_array.sv - single-port storage, synchronous write and read, no reset
module prog_mem_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // rdata only changes on a read, so it holds the last fetched word otherwise.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - loadable program memory with latency-1 reads masked by programmed length
module prog_mem import prog_mem_pkg::*; #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter logic [DATA_W-1:0] NOP_WORD = NOP_DEFAULT[DATA_W-1:0]
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chip_select,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              rd_ready,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic [ADDR_W:0]   prog_len
);

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   prog_len_q;
  logic              rd_valid_q, nop_sel_q, ld_done_q;
  logic              rd_accept, ld_accept, ld_final, in_range, mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  assign in_range = ({1'b0, rd_addr} < prog_len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    rd_ready  = 1'b0;
    ld_ready  = 1'b0;
    rd_accept = 1'b0;
    ld_accept = 1'b0;
    ld_final  = 1'b0;
    case (state_q)
      IDLE: begin
        // A load request takes priority over any read in the same cycle.
        rd_ready  = !ld_start;
        rd_accept = chip_select && rd_req && !ld_start;
        if (ld_start) begin
          state_n = LOAD;
        end
      end
      LOAD: begin
        ld_ready  = 1'b1;
        ld_accept = ld_valid;
        ld_final  = ld_valid && (ld_last || (&wr_ptr_q));
        if (ld_final) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      rd_valid_q <= 1'b0;
      nop_sel_q  <= 1'b1;
      ld_done_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
      ld_done_q  <= ld_final;
      if (rd_accept) begin
        nop_sel_q <= !in_range;
      end
      if (state_q == IDLE && ld_start) begin
        wr_ptr_q   <= '0;
        prog_len_q <= '0;
      end else if (ld_accept) begin
        wr_ptr_q   <= wr_ptr_q + 1'b1;
        prog_len_q <= prog_len_q + 1'b1;
      end
    end
  end

  // Out-of-range reads skip the array; nop_sel_q substitutes the NOP word.
  assign mem_en   = ld_accept || (rd_accept && in_range);
  assign mem_addr = (state_q == LOAD) ? wr_ptr_q : rd_addr;

  prog_mem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .en   (mem_en),
    .we   (ld_accept),
    .addr (mem_addr),
    .wdata(ld_data),
    .rdata(mem_rdata)
  );

  assign data_out = nop_sel_q ? NOP_WORD : mem_rdata;
  assign rd_valid = rd_valid_q;
  assign ld_done  = ld_done_q;
  assign prog_len = prog_len_q;

endmodule
